seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Consumer of the 4 ms divided clock: multiplexes NUM_DIGITS BCD/hex digits onto a common 7-seg bus.
//  Synchronises the free-running scan clock, detects its rising edges, advances one digit per edge,
//  and inserts a dead time between digits to suppress ghosting.
//  Inputs are captured once per frame into shadow regs, so mid-frame data changes never tear the display.
// PARAMETERS
//  NUM_DIGITS     8     digits scanned per frame (2..16); index width = clog2(NUM_DIGITS)
//  DEAD_CYCLES    1000  clk_input cycles with all anodes off before each digit (0 = none)
//  SEG_ACTIVE_LOW 1     1: seg/dp driven low = lit
//  AN_ACTIVE_LOW  1     1: an driven low = digit enabled
// PORTS
//  clk_input   in   1              system clock (100 MHz)
//  rst_n       in   1              async active-low reset
//  scan_clk_in in   1              divided scan clock (level, toggles every 4 ms); asynchronous to logic
//  digits_in   in   4*NUM_DIGITS   nibble k = value of digit k (0-F)
//  dp_in       in   NUM_DIGITS     decimal point per digit (1 = lit)
//  blank_in    in   NUM_DIGITS     1 = digit k dark for the whole frame
//  an          out  NUM_DIGITS     anode enables
//  seg         out  7              segments {g,f,e,d,c,b,a}
//  dp          out  1              decimal point
//  frame_done  out  1              1-cycle pulse when digit index wraps to 0 (shadow reloaded)
// BEHAVIOUR
//  Reset (async, rst_n=0): sync regs=0, state=IDLE, idx=NUM_DIGITS-1, dead_cnt=0, shadow regs=0,
//   an/seg/dp = inactive level (all off), frame_done=0. Outputs registered; reset state held until first edge.
//  Sync: scan_clk_in -> s1 -> s2 (2-flop); s3 <= s2; rise = s2 & ~s3. Falling edges ignored.
//  Rise registered in cycle N -> at N+1: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1; an all off;
//   state <= DEAD (dead_cnt=0) if DEAD_CYCLES>0, else DRIVE directly.
//  Wrap (idx becomes 0): same cycle (N+1) shadow <= {digits_in, dp_in, blank_in}; frame_done=1 for that cycle only.
//  FSM: IDLE -(rise)-> DEAD | DRIVE;  DEAD -(dead_cnt==DEAD_CYCLES-1)-> DRIVE;  DRIVE -(rise)-> DEAD | DRIVE.
//   DEAD: an all off, seg/dp off, dead_cnt increments. Cycle count in DEAD is exactly DEAD_CYCLES.
//   DRIVE: an[idx] active unless shadow_blank[idx]; seg = decode(shadow_digit[idx]); dp = shadow_dp[idx].
//   Blanked digit: an all off, seg/dp off, timing unchanged (idx still advances).
//  Rise during DEAD: idx advances again, dead_cnt restarts at 0 (a skipped digit is acceptable).
//  Decode (lit bits, gfedcba): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101
//   7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001 d=1011110 E=1111001 F=1110001.
//   Output polarity applied after decode; an polarity likewise. Only one an bit ever active.
//  Latency: scan_clk_in rise -> an change = 3 cycles (sync+detect+reg) + DEAD_CYCLES; jitter <= 1 cycle.
//  Reset mid-DRIVE: outputs go off immediately (async); restart from IDLE, first rise shows digit 0.
//  dead_cnt width = clog2(DEAD_CYCLES+1); no overflow since count stops at DEAD_CYCLES-1.
// TESTING
//  T1 reset: rst_n=0 with scan_clk_in toggling -> an=8'hFF, seg=7'h7F, dp=1, frame_done=0 (active-low defaults).
//  T2 first frame: digits_in=32'h7654_3210, DEAD_CYCLES=4; 1st rise -> frame_done pulse at N+1, an=FF 4 cycles,
//     then an=8'hFE, seg=~7'b0111111; next rise -> an=8'hFD, seg=~7'b0000110 after 4 dead cycles.
//  T3 wrap/shadow: change digits_in to 32'hFFFF_FFFF mid-frame -> digits 1..7 keep old values; after 8th rise
//     idx=0, frame_done=1, digit 0 shows F (~7'b1110001).
//  T4 blank/dp: blank_in=8'h02, dp_in=8'h01 -> digit0 dp=0 (lit); digit1 slot an=FF and seg/dp off for full slot.
//  T5 rise during DEAD (DEAD_CYCLES=1000, rises 10 cycles apart) -> idx advances twice, an stays FF, no two-hot an.
//  T6 async reset mid-DRIVE (an=8'hFB) -> an=FF same cycle as rst_n fall; after release, first rise drives digit 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes NUM_DIGITS hex digits onto one 7-segment bus.
// The asynchronous scan clock is synchronised and edge-detected; each rising edge
// advances to the next digit after a dead time with all anodes off. Digit data is
// captured into shadow registers once per frame (when the index wraps to 0).
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int DEAD_CYCLES    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk_input,
    input  logic                    rst_n,
    input  logic                    scan_clk_in,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    // Keep the counter at least one bit wide so DEAD_CYCLES=0 still elaborates.
    localparam int CNT_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Lit-segment pattern {g,f,e,d,c,b,a} for a hex value; polarity is applied later.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'b0111111;
            4'h1: r = 7'b0000110;
            4'h2: r = 7'b1011011;
            4'h3: r = 7'b1001111;
            4'h4: r = 7'b1100110;
            4'h5: r = 7'b1101101;
            4'h6: r = 7'b1111101;
            4'h7: r = 7'b0000111;
            4'h8: r = 7'b1111111;
            4'h9: r = 7'b1101111;
            4'hA: r = 7'b1110111;
            4'hB: r = 7'b1111100;
            4'hC: r = 7'b0111001;
            4'hD: r = 7'b1011110;
            4'hE: r = 7'b1111001;
            default: r = 7'b1110001;
        endcase
        return r;
    endfunction

    logic s1_q, s2_q, s3_q, rise_q;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d, idx_next;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]     sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]          sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]          sh_blank_q, sh_blank_d;
    logic [NUM_DIGITS-1:0]          an_q, an_d;
    logic [6:0]                     seg_q, seg_d;
    logic                           dp_q, dp_d;
    logic                           fd_q, fd_d;
    logic [NUM_DIGITS-1:0]          onehot;
    logic [6:0]                     lit;

    // Two-flop synchroniser for the scan clock, a third flop for edge detection,
    // and a registered rising-edge strobe.
    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= scan_clk_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
        end
    end

    // State, digit index, dead-time counter, shadow data and registered outputs.
    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= IDX_LAST;
            cnt_q      <= '0;
            sh_dig_q   <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sh_dig_q   <= sh_dig_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they change
    // in the same cycle as the state they belong to.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        sh_dig_d   = sh_dig_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        fd_d       = 1'b0;
        an_d       = AN_OFF;
        seg_d      = SEG_OFF;
        dp_d       = DP_OFF;
        onehot     = '0;
        lit        = '0;
        idx_next   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;

        if (rise_q) begin
            // A rise always wins, even mid-dead-time: advance and restart the gap.
            idx_d   = idx_next;
            cnt_d   = '0;
            state_d = (DEAD_CYCLES > 0) ? DEAD : DRIVE;
            if (idx_next == '0) begin
                sh_dig_d   = digits_in;
                sh_dp_d    = dp_in;
                sh_blank_d = blank_in;
                fd_d       = 1'b1;
            end
        end else begin
            case (state_q)
                DEAD: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = DRIVE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end

        if (state_d == DRIVE && !sh_blank_d[idx_d]) begin
            onehot[idx_d] = 1'b1;
            lit           = seg_decode(sh_dig_d[idx_d]);
            an_d          = AN_ACTIVE_LOW ? ~onehot : onehot;
            seg_d         = SEG_ACTIVE_LOW ? ~lit : lit;
            dp_d          = sh_dp_d[idx_d] ? ~DP_OFF : DP_OFF;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: short-dead-time instance for frame/shadow/blank/reset
// behaviour, long-dead-time instance for rises arriving during the dead time.
module tb_seg7_scan_driver;

    typedef struct {
        logic [31:0] dig;
        logic [7:0]  dpv;
        logic [7:0]  blk;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fd;
    } vec_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        scan_a = 1'b0, scan_l = 1'b0;
    logic [31:0] digits_a = '0, digits_l = '0;
    logic [7:0]  dp_a = '0, dp_l = '0, blank_a = '0, blank_l = '0;
    logic [7:0]  an_a, an_l;
    logic [6:0]  seg_a, seg_l;
    logic        dpo_a, dpo_l, fd_a, fd_l;

    int   checks = 0;
    int   failures = 0;
    vec_t tbl[28];
    exp_t sbq[$];
    logic [6:0] seglit[16];

    seg7_scan_driver #(.NUM_DIGITS(8), .DEAD_CYCLES(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk_input(clk), .rst_n(rst_n), .scan_clk_in(scan_a), .digits_in(digits_a),
        .dp_in(dp_a), .blank_in(blank_a), .an(an_a), .seg(seg_a), .dp(dpo_a), .frame_done(fd_a)
    );

    seg7_scan_driver #(.NUM_DIGITS(8), .DEAD_CYCLES(1000), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_long (
        .clk_input(clk), .rst_n(rst_n), .scan_clk_in(scan_l), .digits_in(digits_l),
        .dp_in(dp_l), .blank_in(blank_l), .an(an_l), .seg(seg_l), .dp(dpo_l), .frame_done(fd_l)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // k = digit slot, v = value shown, bl = blanked, dl = dp lit
    function automatic vec_t mk(input logic [31:0] dig, input logic [7:0] dpv, input logic [7:0] blk,
                                input int k, input int v, input bit bl, input bit dl, input bit fd);
        vec_t r;
        logic [7:0] oh;
        oh    = 8'b1 << k;
        r.dig = dig;
        r.dpv = dpv;
        r.blk = blk;
        r.an  = bl ? 8'hFF : ~oh;
        r.seg = bl ? 7'h7F : ~seglit[v];
        r.dp  = (bl || !dl) ? 1'b1 : 1'b0;
        r.fd  = fd;
        return r;
    endfunction

    // One scan slot on the short instance: apply inputs, raise the scan clock,
    // check the frame pulse and the 4-cycle dead time, then the driven digit.
    task automatic run_slot(input vec_t r);
        exp_t e;
        digits_a = r.dig;
        dp_a     = r.dpv;
        blank_a  = r.blk;
        e.an = r.an; e.seg = r.seg; e.dp = r.dp;
        sbq.push_back(e);
        @(negedge clk);
        scan_a = 1'b1;
        repeat (4) @(negedge clk);
        chk("frame_done_at_step", 32'(fd_a), 32'(r.fd));
        chk("dead_an_first", 32'(an_a), 32'hFF);
        scan_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("dead_an", 32'(an_a), 32'hFF);
            chk("dead_seg", 32'(seg_a), 32'h7F);
            chk("dead_dp", 32'(dpo_a), 32'h1);
            chk("frame_done_low", 32'(fd_a), 32'h0);
        end
        @(negedge clk);
        if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            e = sbq.pop_front();
            chk("drive_an", 32'(an_a), 32'(e.an));
            chk("drive_seg", 32'(seg_a), 32'(e.seg));
            chk("drive_dp", 32'(dpo_a), 32'(e.dp));
            chk("drive_fd_low", 32'(fd_a), 32'h0);
            repeat (2) begin
                @(negedge clk);
                chk("hold_an", 32'(an_a), 32'(e.an));
                chk("hold_seg", 32'(seg_a), 32'(e.seg));
            end
        end
    endtask

    initial begin
        int bad;
        exp_t e;
        seglit = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                   7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                   7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                   7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        // Frame 1: digits 0..7; inputs change from slot 3 on and must not show.
        for (int k = 0; k < 8; k++)
            tbl[k] = (k < 3) ? mk(32'h7654_3210, 8'h00, 8'h00, k, k, 1'b0, 1'b0, k == 0)
                             : mk(32'hFFFF_FFFF, 8'h01, 8'h02, k, k, 1'b0, 1'b0, 1'b0);
        // Frame 2: all F, dp on digit 0, digit 1 blanked; inputs change from slot 3.
        for (int k = 0; k < 8; k++)
            tbl[8+k] = (k < 3) ? mk(32'hFFFF_FFFF, 8'h01, 8'h02, k, 15, k == 1, k == 0, k == 0)
                               : mk(32'h89AB_CDEF, 8'h00, 8'h00, k, 15, k == 1, k == 0, 1'b0);
        // Frame 3 and start of frame 4: digit k shows 15-k.
        for (int k = 0; k < 8; k++)
            tbl[16+k] = mk(32'h89AB_CDEF, 8'h00, 8'h00, k, 15 - k, 1'b0, 1'b0, k == 0);
        for (int k = 0; k < 3; k++)
            tbl[24+k] = mk(32'h89AB_CDEF, 8'h00, 8'h00, k, 15 - k, 1'b0, 1'b0, k == 0);
        // First slot after the mid-drive reset.
        tbl[27] = mk(32'h0000_00A5, 8'h00, 8'h00, 0, 5, 1'b0, 1'b0, 1'b1);

        // Reset with the scan clock toggling.
        #1 rst_n = 1'b0;
        repeat (6) begin
            @(negedge clk);
            scan_a = ~scan_a;
            scan_l = ~scan_l;
        end
        @(negedge clk);
        chk("reset_an", 32'(an_a), 32'hFF);
        chk("reset_seg", 32'(seg_a), 32'h7F);
        chk("reset_dp", 32'(dpo_a), 32'h1);
        chk("reset_fd", 32'(fd_a), 32'h0);
        chk("reset_an_long", 32'(an_l), 32'hFF);
        scan_a = 1'b0;
        scan_l = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_an", 32'(an_a), 32'hFF);
        chk("idle_seg", 32'(seg_a), 32'h7F);
        chk("idle_fd", 32'(fd_a), 32'h0);

        for (int i = 0; i < 27; i++) run_slot(tbl[i]);

        // Rises during the dead time on the long instance.
        digits_l = 32'h7654_3210;
        dp_l = 8'h00;
        blank_l = 8'h00;
        e.an = 8'hFD; e.seg = ~seglit[1]; e.dp = 1'b1;
        sbq.push_back(e);
        @(negedge clk);
        scan_l = 1'b1;
        repeat (4) @(negedge clk);
        chk("long_fd_first", 32'(fd_l), 32'h1);
        chk("long_an_first", 32'(an_l), 32'hFF);
        @(negedge clk);
        scan_l = 1'b0;
        repeat (5) @(negedge clk);
        scan_l = 1'b1;
        repeat (4) @(negedge clk);
        chk("long_fd_second", 32'(fd_l), 32'h0);
        chk("long_an_second", 32'(an_l), 32'hFF);
        scan_l = 1'b0;
        bad = 0;
        repeat (999) begin
            @(negedge clk);
            if (an_l !== 8'hFF || fd_l !== 1'b0) bad++;
        end
        chk("long_dead_window_violations", 32'(bad), 32'h0);
        @(negedge clk);
        e = sbq.pop_front();
        chk("long_an_digit1", 32'(an_l), 32'(e.an));
        chk("long_seg_digit1", 32'(seg_l), 32'(e.seg));
        chk("long_dp_digit1", 32'(dpo_l), 32'(e.dp));

        // Asynchronous reset while digit 2 is being driven.
        chk("pre_reset_an", 32'(an_a), 32'hFB);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_an", 32'(an_a), 32'hFF);
        chk("async_reset_seg", 32'(seg_a), 32'h7F);
        chk("async_reset_dp", 32'(dpo_a), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle_an", 32'(an_a), 32'hFF);
        run_slot(tbl[27]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
